// File: rtl/wb_mem_2_ppfifo_mb.sv
// Wishbone read master that drains per-bank memory blocks, round-robin, into a ping-pong FIFO.
// Latency: one beat in flight; an acked word is strobed into the PPFIFO on the following cycle.
// Backpressure: holds cyc/stb low while no PPFIFO side is active or the active side is full.
module wb_mem_2_ppfifo_mb #(
  parameter int BANK_COUNT     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_INC       = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_enable,
  input  logic [32*BANK_COUNT-1:0]  i_bank_base,
  input  logic [32*BANK_COUNT-1:0]  i_bank_size,
  input  logic [BANK_COUNT-1:0]     i_bank_new_data,
  output logic [32*BANK_COUNT-1:0]  o_bank_count,
  output logic [BANK_COUNT-1:0]     o_bank_empty,
  output logic                      o_read_finished,
  output logic [2:0]                o_finished_bank,
  output logic                      o_bus_error,
  output logic                      o_mem_we,
  output logic                      o_mem_stb,
  output logic                      o_mem_cyc,
  output logic [DATA_WIDTH/8-1:0]   o_mem_sel,
  output logic [31:0]               o_mem_adr,
  output logic [DATA_WIDTH-1:0]     o_mem_dat,
  input  logic [DATA_WIDTH-1:0]     i_mem_dat,
  input  logic                      i_mem_ack,
  input  logic [1:0]                i_ppfifo_rdy,
  output logic [1:0]                o_ppfifo_act,
  input  logic [23:0]               i_ppfifo_size,
  output logic                      o_ppfifo_stb,
  output logic [DATA_WIDTH-1:0]     o_ppfifo_data
);

  // Bank index width; per-bank arrays are padded to a power of two so any index is in range.
  localparam int IW = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1;
  localparam int NB = 1 << IW;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SELECT   = 3'd1;
  localparam logic [2:0] ST_READ     = 3'd2;
  localparam logic [2:0] ST_FINISHED = 3'd3;
  localparam logic [2:0] ST_ABORT    = 3'd4;

  logic [2:0]    r_state;
  logic [31:0]   r_ptr [NB];
  logic [IW-1:0] r_active;
  logic [IW-1:0] r_last;
  logic [31:0]   r_limit;
  logic          r_cyc;
  logic          r_stb;
  logic          r_ppfifo_stb;
  logic [1:0]    r_act;
  logic [23:0]   r_fifo_cnt;
  logic [31:0]   r_tmo;

  logic [31:0]   w_size  [NB];
  logic [31:0]   w_base  [NB];
  logic [31:0]   w_count [NB];
  logic [NB-1:0] w_new;
  logic          w_found;
  logic [IW-1:0] w_sel;
  logic [IW-1:0] w_idx;
  logic          w_ack;
  logic          w_tmo_hit;

  for (genvar k = 0; k < NB; k++) begin : g_bank
    if (k < BANK_COUNT) begin : g_real
      assign w_size[k]              = i_bank_size[32*k +: 32];
      assign w_base[k]              = i_bank_base[32*k +: 32];
      assign w_new[k]               = i_bank_new_data[k];
      assign w_count[k]             = w_size[k] - r_ptr[k];
      assign o_bank_count[32*k +: 32] = w_count[k];
      assign o_bank_empty[k]        = (w_count[k] == 32'd0);
    end else begin : g_pad
      assign w_size[k]  = 32'd0;
      assign w_base[k]  = 32'd0;
      assign w_new[k]   = 1'b0;
      assign w_count[k] = 32'd0;
    end
  end

  assign w_ack     = r_stb & i_mem_ack;
  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && r_stb && !i_mem_ack &&
                     ((r_tmo + 32'd1) == 32'(TIMEOUT_CYCLES));

  // Round-robin search for the next non-empty bank, starting after the last one served
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int i = 0; i < BANK_COUNT; i++) begin
      w_idx = IW'((int'(r_last) + 1 + i) % BANK_COUNT);
      if (!w_found && w_size[w_idx] != 32'd0 && w_count[w_idx] != 32'd0) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  // Sequencer: block state, single-beat Wishbone strobing, timeout and PPFIFO side handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_active     <= '0;
      r_last       <= IW'(BANK_COUNT - 1);
      r_limit      <= '0;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_ppfifo_stb <= 1'b0;
      r_act        <= 2'b00;
      r_fifo_cnt   <= '0;
      r_tmo        <= '0;
    end else begin
      r_ppfifo_stb <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cyc <= 1'b0;
          r_stb <= 1'b0;
          if (i_enable) r_state <= ST_SELECT;
        end
        ST_SELECT: begin
          if (!i_enable) begin
            r_state <= ST_IDLE;
          end else if (w_found) begin
            r_active <= w_sel;
            r_last   <= w_sel;
            r_limit  <= w_size[w_sel];
            r_state  <= ST_READ;
          end
        end
        ST_READ: begin
          if (w_ack) begin
            r_stb        <= 1'b0;
            r_tmo        <= '0;
            r_ppfifo_stb <= 1'b1;
            r_fifo_cnt   <= r_fifo_cnt + 24'd1;
          end else if (r_stb) begin
            if (w_tmo_hit) begin
              r_cyc   <= 1'b0;
              r_stb   <= 1'b0;
              r_tmo   <= '0;
              r_state <= ST_ABORT;
            end else begin
              r_tmo <= r_tmo + 32'd1;
            end
          end
          // A restart of the active bank abandons the block; an ack in this cycle is still forwarded.
          if (w_new[r_active]) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_tmo   <= '0;
            r_state <= ST_SELECT;
          end else if (!r_stb) begin
            if (!i_enable) begin
              r_cyc      <= 1'b0;
              r_act      <= 2'b00;
              r_fifo_cnt <= '0;
              r_state    <= ST_IDLE;
            end else if (r_ptr[r_active] == r_limit) begin
              r_cyc   <= 1'b0;
              r_state <= ST_FINISHED;
            end else if (r_act == 2'b00) begin
              r_cyc <= 1'b0;
            end else if (r_fifo_cnt >= i_ppfifo_size) begin
              r_cyc <= 1'b0;
              r_act <= 2'b00;
            end else begin
              r_cyc <= 1'b1;
              r_stb <= 1'b1;
            end
          end
        end
        ST_FINISHED, ST_ABORT: begin
          if (r_fifo_cnt != 24'd0) begin
            r_act      <= 2'b00;
            r_fifo_cnt <= '0;
          end
          r_state <= ST_SELECT;
        end
        default: r_state <= ST_IDLE;
      endcase
      // Grab a ready PPFIFO side whenever none is held; side 0 preferred
      if (i_enable && r_act == 2'b00 && i_ppfifo_rdy != 2'b00) begin
        r_act      <= i_ppfifo_rdy[0] ? 2'b01 : 2'b10;
        r_fifo_cnt <= '0;
      end
    end
  end

  // Per-bank read pointers: a new-data clear beats a same-cycle increment or abort fill
  always_ff @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (!rst_n) begin
        r_ptr[k] <= '0;
      end else if (w_new[k]) begin
        r_ptr[k] <= '0;
      end else if (r_active == IW'(k)) begin
        if (r_state == ST_READ && w_ack) r_ptr[k] <= r_ptr[k] + 32'd1;
        else if (r_state == ST_ABORT)    r_ptr[k] <= w_size[k];
      end
    end
  end

  assign o_mem_adr       = w_base[r_active] + r_ptr[r_active] * 32'(ADDR_INC);
  assign o_mem_cyc       = r_cyc;
  assign o_mem_stb       = r_stb;
  assign o_mem_we        = 1'b0;
  assign o_mem_sel       = '1;
  assign o_mem_dat       = '0;
  assign o_ppfifo_act    = r_act;
  assign o_ppfifo_stb    = r_ppfifo_stb;
  assign o_ppfifo_data   = i_mem_dat;
  assign o_read_finished = (r_state == ST_FINISHED);
  assign o_bus_error     = (r_state == ST_ABORT);
  assign o_finished_bank = 3'(r_active);

endmodule

// File: tb/tb_wb_mem_2_ppfifo_mb.sv
// Bench for wb_mem_2_ppfifo_mb: table of block-transfer scenarios plus timeout, enable-drop and restart sequences.
// A Wishbone slave model acks and feeds a scoreboard of expected addresses and PPFIFO data.
// The PPFIFO model flips its ready side each time the DUT releases a side.
module tb_wb_mem_2_ppfifo_mb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_enable;
  logic [127:0] i_bank_base;
  logic [127:0] i_bank_size;
  logic [3:0]   i_bank_new_data;
  logic [127:0] o_bank_count;
  logic [3:0]   o_bank_empty;
  logic         o_read_finished;
  logic [2:0]   o_finished_bank;
  logic         o_bus_error;
  logic         o_mem_we, o_mem_stb, o_mem_cyc;
  logic [3:0]   o_mem_sel;
  logic [31:0]  o_mem_adr;
  logic [31:0]  o_mem_dat;
  logic [31:0]  i_mem_dat;
  logic         i_mem_ack;
  logic [1:0]   i_ppfifo_rdy;
  logic [1:0]   o_ppfifo_act;
  logic [23:0]  i_ppfifo_size;
  logic         o_ppfifo_stb;
  logic [31:0]  o_ppfifo_data;

  wb_mem_2_ppfifo_mb #(
    .BANK_COUNT(4), .DATA_WIDTH(32), .ADDR_INC(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable),
    .i_bank_base(i_bank_base), .i_bank_size(i_bank_size), .i_bank_new_data(i_bank_new_data),
    .o_bank_count(o_bank_count), .o_bank_empty(o_bank_empty),
    .o_read_finished(o_read_finished), .o_finished_bank(o_finished_bank), .o_bus_error(o_bus_error),
    .o_mem_we(o_mem_we), .o_mem_stb(o_mem_stb), .o_mem_cyc(o_mem_cyc), .o_mem_sel(o_mem_sel),
    .o_mem_adr(o_mem_adr), .o_mem_dat(o_mem_dat), .i_mem_dat(i_mem_dat), .i_mem_ack(i_mem_ack),
    .i_ppfifo_rdy(i_ppfifo_rdy), .o_ppfifo_act(o_ppfifo_act), .i_ppfifo_size(i_ppfifo_size),
    .o_ppfifo_stb(o_ppfifo_stb), .o_ppfifo_data(o_ppfifo_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][31:0] base;
    logic [3:0][31:0] size;
    logic [23:0]      fsz;
    logic [7:0]       beats;
    logic [2:0]       n_fin;
    logic [3:0][2:0]  fin;
    logic [2:0]       n_chunk;
    logic [3:0][7:0]  chunk;
  } vec_t;

  vec_t        vecs [4];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_adr [$];
  logic [31:0] exp_dat [$];
  int          got_fin [$];
  int          got_err [$];
  int          got_chunk [$];
  int          n_stb, n_stb_noact, n_ack, ack_limit, cur_beats;
  logic [1:0]  prev_act;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (no expected event within bound)", name);
  endtask

  function automatic logic [31:0] bcount(input int k);
    return o_bank_count[32*k +: 32];
  endfunction

  task automatic do_reset(input logic [127:0] base, input logic [127:0] size, input logic [23:0] fsz);
    rst_n = 1'b0;
    i_enable = 1'b0;
    i_bank_new_data = 4'b0;
    i_bank_base = base;
    i_bank_size = size;
    i_ppfifo_size = fsz;
    repeat (2) @(negedge clk);
    exp_adr.delete(); exp_dat.delete();
    got_fin.delete(); got_err.delete(); got_chunk.delete();
    n_stb = 0; n_stb_noact = 0; n_ack = 0; cur_beats = 0;
    rst_n = 1'b1;
  endtask

  task automatic wait_fin(input int n, input string name);
    for (int c = 0; c < 600 && got_fin.size() < n; c++) @(negedge clk);
    if (got_fin.size() < n) fail(name);
  endtask

  task automatic push_block(input logic [31:0] base, input int first, input int last);
    for (int p = first; p <= last; p++) exp_adr.push_back(base + 32'(p) * 32'd4);
  endtask

  // Wishbone slave, PPFIFO model and output monitor, all on the falling edge
  initial begin
    i_mem_ack = 1'b0;
    i_mem_dat = '0;
    i_ppfifo_rdy = 2'b01;
    prev_act = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        i_mem_ack = 1'b0;
        prev_act = 2'b00;
      end else begin
        if (o_ppfifo_stb) begin
          n_stb++;
          cur_beats++;
          if (o_ppfifo_act == 2'b00) n_stb_noact++;
          if (exp_dat.size() == 0) fail("ppfifo_dat_unexpected");
          else chk("ppfifo_dat", o_ppfifo_data, exp_dat.pop_front());
        end
        if (o_read_finished) got_fin.push_back(int'(o_finished_bank));
        if (o_bus_error) got_err.push_back(int'(o_finished_bank));
        if (prev_act != 2'b00 && o_ppfifo_act == 2'b00) begin
          if (cur_beats > 0) got_chunk.push_back(cur_beats);
          cur_beats = 0;
          i_ppfifo_rdy = (i_ppfifo_rdy == 2'b01) ? 2'b10 : 2'b01;
        end
        prev_act = o_ppfifo_act;
        if (i_mem_ack) begin
          i_mem_ack = 1'b0;
        end else if (o_mem_stb && o_mem_cyc && n_ack < ack_limit) begin
          if (exp_adr.size() == 0) fail("wb_adr_unexpected");
          else chk("wb_adr", o_mem_adr, exp_adr.pop_front());
          i_mem_dat = o_mem_adr ^ 32'hC0DE_0000;
          exp_dat.push_back(i_mem_dat);
          n_ack++;
          i_mem_ack = 1'b1;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Scenario table: single bank, multi-bank order, PPFIFO side splitting, zero-size skip
    vecs[0] = '0;
    vecs[0].base[0] = 32'h100; vecs[0].size[0] = 32'd4; vecs[0].fsz = 24'd8;
    vecs[0].beats = 8'd4; vecs[0].n_fin = 3'd1; vecs[0].fin[0] = 3'd0;
    vecs[0].n_chunk = 3'd1; vecs[0].chunk[0] = 8'd4;
    vecs[1] = '0;
    vecs[1].base = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
    vecs[1].size = {32'd2, 32'd2, 32'd0, 32'd2}; vecs[1].fsz = 24'd8;
    vecs[1].beats = 8'd6; vecs[1].n_fin = 3'd3; vecs[1].fin = {3'd0, 3'd3, 3'd2, 3'd0};
    vecs[1].n_chunk = 3'd3; vecs[1].chunk = {8'd0, 8'd2, 8'd2, 8'd2};
    vecs[2] = '0;
    vecs[2].base[1] = 32'h8000; vecs[2].size[1] = 32'd10; vecs[2].fsz = 24'd4;
    vecs[2].beats = 8'd10; vecs[2].n_fin = 3'd1; vecs[2].fin[0] = 3'd1;
    vecs[2].n_chunk = 3'd3; vecs[2].chunk = {8'd0, 8'd2, 8'd4, 8'd4};
    vecs[3] = '0;
    vecs[3].base = {32'h7000, 32'h6000, 32'h5000, 32'h4400};
    vecs[3].size = {32'd3, 32'd0, 32'd1, 32'd0}; vecs[3].fsz = 24'd8;
    vecs[3].beats = 8'd4; vecs[3].n_fin = 3'd2; vecs[3].fin = {3'd0, 3'd0, 3'd3, 3'd1};
    vecs[3].n_chunk = 3'd2; vecs[3].chunk = {8'd0, 8'd0, 8'd3, 8'd1};

    ack_limit = 1000;
    do_reset('0, '0, 24'd8);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_cyc", o_mem_cyc, 0);
    chk("rst_stb", o_mem_stb, 0);
    chk("rst_we", o_mem_we, 0);
    chk("rst_sel", o_mem_sel, 4'hF);
    chk("rst_mem_dat", o_mem_dat, 0);
    chk("rst_act", o_ppfifo_act, 0);
    chk("rst_ppfifo_stb", o_ppfifo_stb, 0);
    chk("rst_finished", o_read_finished, 0);
    chk("rst_bus_error", o_bus_error, 0);
    chk("rst_fin_bank", o_finished_bank, 0);
    chk("rst_empty", o_bank_empty, 4'hF);

    for (int v = 0; v < 4; v++) begin
      do_reset(vecs[v].base, vecs[v].size, vecs[v].fsz);
      ack_limit = 1000;
      for (int f = 0; f < int'(vecs[v].n_fin); f++)
        push_block(vecs[v].base[vecs[v].fin[f]], 0, int'(vecs[v].size[vecs[v].fin[f]]) - 1);
      i_enable = 1'b1;
      wait_fin(int'(vecs[v].n_fin), $sformatf("v%0d_finish", v));
      repeat (6) @(negedge clk);
      chk($sformatf("v%0d_beats", v), n_stb, vecs[v].beats);
      chk($sformatf("v%0d_stb_noact", v), n_stb_noact, 0);
      chk($sformatf("v%0d_adr_left", v), exp_adr.size(), 0);
      chk($sformatf("v%0d_bus_err", v), got_err.size(), 0);
      chk($sformatf("v%0d_n_fin", v), got_fin.size(), vecs[v].n_fin);
      for (int f = 0; f < got_fin.size() && f < int'(vecs[v].n_fin); f++)
        chk($sformatf("v%0d_fin%0d", v, f), got_fin[f], vecs[v].fin[f]);
      chk($sformatf("v%0d_n_chunk", v), got_chunk.size(), vecs[v].n_chunk);
      for (int c = 0; c < got_chunk.size() && c < int'(vecs[v].n_chunk); c++)
        chk($sformatf("v%0d_chunk%0d", v, c), got_chunk[c], vecs[v].chunk[c]);
      chk($sformatf("v%0d_all_empty", v), o_bank_empty, 4'hF);
    end

    // Timeout: slave never acks, bank 2 must abort after 16 strobe cycles and be emptied
    do_reset({32'h0, 32'h500, 32'h0, 32'h0}, {32'd0, 32'd5, 32'd0, 32'd0}, 24'd8);
    ack_limit = 0;
    i_enable = 1'b1;
    begin
      int hi;
      hi = 0;
      for (int c = 0; c < 50 && !o_mem_stb; c++) @(negedge clk);
      if (!o_mem_stb) fail("tmo_stb_start");
      while (o_mem_stb && hi < 100) begin
        hi++;
        @(negedge clk);
      end
      chk("tmo_stb_cycles", hi, 16);
      chk("tmo_cyc_drop", o_mem_cyc, 0);
    end
    repeat (4) @(negedge clk);
    chk("tmo_n_err", got_err.size(), 1);
    if (got_err.size() > 0) chk("tmo_err_bank", got_err[0], 2);
    chk("tmo_no_fin", got_fin.size(), 0);
    chk("tmo_empty2", o_bank_empty[2], 1);
    chk("tmo_count2", bcount(2), 0);
    chk("tmo_cyc_idle", o_mem_cyc, 0);

    // Enable drop mid-block: outstanding beat completes, PPFIFO flushed, pointer kept
    do_reset({32'h300, 32'h0, 32'h0, 32'h0}, {32'd6, 32'd0, 32'd0, 32'd0}, 24'd8);
    ack_limit = 2;
    push_block(32'h300, 0, 5);
    i_enable = 1'b1;
    for (int c = 0; c < 100 && n_ack < 2; c++) @(negedge clk);
    if (n_ack < 2) fail("dis_two_acks");
    repeat (3) @(negedge clk);
    chk("dis_stall_stb", o_mem_stb, 1);
    i_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("dis_wait_ack", o_mem_stb, 1);
    ack_limit = 100;
    repeat (6) @(negedge clk);
    chk("dis_cyc", o_mem_cyc, 0);
    chk("dis_act", o_ppfifo_act, 0);
    chk("dis_count3", bcount(3), 3);
    chk("dis_beats", n_stb, 3);
    chk("dis_no_fin", got_fin.size(), 0);
    i_enable = 1'b1;
    wait_fin(1, "dis_resume_finish");
    repeat (4) @(negedge clk);
    chk("dis_total_beats", n_stb, 6);
    if (got_fin.size() > 0) chk("dis_fin_bank", got_fin[0], 3);
    chk("dis_adr_left", exp_adr.size(), 0);

    // New data on the active bank after 3 of 8 beats restarts the block at its base
    do_reset({32'h0, 32'h0, 32'h0, 32'h200}, {32'd0, 32'd0, 32'd0, 32'd8}, 24'd16);
    ack_limit = 3;
    push_block(32'h200, 0, 2);
    push_block(32'h200, 0, 7);
    i_enable = 1'b1;
    for (int c = 0; c < 100 && n_ack < 3; c++) @(negedge clk);
    if (n_ack < 3) fail("nd_three_acks");
    repeat (4) @(negedge clk);
    chk("nd_stall_stb", o_mem_stb, 1);
    chk("nd_stall_adr", o_mem_adr, 32'h20C);
    i_bank_new_data = 4'b0001;
    @(negedge clk);
    i_bank_new_data = 4'b0000;
    chk("nd_cyc_drop", o_mem_cyc, 0);
    chk("nd_count0", bcount(0), 8);
    chk("nd_no_fin", got_fin.size(), 0);
    ack_limit = 100;
    wait_fin(1, "nd_finish");
    repeat (4) @(negedge clk);
    chk("nd_total_beats", n_stb, 11);
    chk("nd_n_fin", got_fin.size(), 1);
    if (got_fin.size() > 0) chk("nd_fin_bank", got_fin[0], 0);
    chk("nd_adr_left", exp_adr.size(), 0);
    chk("nd_bus_err", got_err.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
